// File: rtl/systolic_skew_feeder_pkg.sv
// Shared state encoding, default geometry and lane-slice helper for the
// systolic edge feeders, the PE array top and the PEs.
package systolic_skew_feeder_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FULL = 2'd1,
    RUN  = 2'd2
  } feed_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LANES      = 4;
  localparam int DEF_DEPTH      = 4;

  // LSB of a lane's element inside a packed LANES*width vector.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_feed_buffer.sv
// Tile register file: one write port for whole vectors, and one read port per
// lane so every lane can fetch its own (skewed) row in the same cycle.
module feed_buffer
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           waddr,
  input  logic [LANES*DATA_WIDTH-1:0] wdata,
  input  logic [LANES*ADDR_W-1:0]     raddr,
  output logic [LANES*DATA_WIDTH-1:0] rdata
);

  logic [LANES*DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_rd
      assign rdata[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] =
        mem[raddr[gi*ADDR_W +: ADDR_W]][lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
    end
  endgenerate

endmodule

// File: rtl/systolic_skew_feeder.sv
// Edge feeder: buffers a DEPTH-vector tile, then replays it with lane i
// delayed i cycles so the PE array sees a diagonal wavefront without stalls.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        fire,
  output logic                        full,
  output logic [LANES*DATA_WIDTH-1:0] lane_out,
  output logic                        feed_valid,
  output logic                        done
);

  localparam int T      = DEPTH + LANES - 1;
  localparam int CNT_W  = $clog2(DEPTH + LANES);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int VW     = LANES * DATA_WIDTH;

  feed_state_t state_reg, state_next;
  logic [CNT_W-1:0] wr_cnt_reg, wr_cnt_next;
  logic [CNT_W-1:0] t_reg, t_next;
  logic accept, last_wr, last_step;
  logic [LANES*ADDR_W-1:0] raddr;
  logic [VW-1:0] rdata, lane_next;

  assign accept    = in_valid && in_ready;
  assign last_wr   = (wr_cnt_reg == CNT_W'(DEPTH - 1));
  assign last_step = (t_reg == CNT_W'(T - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= LOAD;
      wr_cnt_reg <= '0;
      t_reg      <= '0;
    end else begin
      state_reg  <= state_next;
      wr_cnt_reg <= wr_cnt_next;
      t_reg      <= t_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wr_cnt_next = wr_cnt_reg;
    t_next      = '0;
    case (state_reg)
      LOAD: begin
        if (accept) begin
          wr_cnt_next = last_wr ? '0 : wr_cnt_reg + CNT_W'(1);
          if (last_wr) state_next = FULL;
        end
      end
      FULL: begin
        if (fire) state_next = RUN;
      end
      RUN: begin
        if (last_step) state_next = LOAD;
        else           t_next = t_reg + CNT_W'(1);
      end
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    full     = 1'b0;
    case (state_reg)
      LOAD:    in_ready = 1'b1;
      FULL:    full     = 1'b1;
      default: ;
    endcase
  end

  feed_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .LANES     (LANES),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_buf (
    .clk  (clk),
    .we   (accept),
    .waddr(wr_cnt_reg[ADDR_W-1:0]),
    .wdata(in_data),
    .raddr(raddr),
    .rdata(rdata)
  );

  // Lane i replays row t-i; outside the tile's diagonal band it feeds zero.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [CNT_W-1:0] row;
      logic hit;
      assign row = t_reg - CNT_W'(gi);
      assign hit = (t_reg >= CNT_W'(gi)) && (row < CNT_W'(DEPTH));
      assign raddr[gi*ADDR_W +: ADDR_W] = row[ADDR_W-1:0];
      assign lane_next[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] =
        hit ? rdata[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_out   <= '0;
      feed_valid <= 1'b0;
      done       <= 1'b0;
    end else if (state_reg == RUN) begin
      lane_out   <= lane_next;
      feed_valid <= 1'b1;
      done       <= last_step;
    end else begin
      lane_out   <= '0;
      feed_valid <= 1'b0;
      done       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: tile-level reference model checked every
// cycle, hand-computed skew checks, and an end-to-end 4x4 PE array run.
`timescale 1ns/1ps
module tb_systolic_skew_feeder;

  localparam int DW    = 32;
  localparam int LANES = 4;
  localparam int DEPTH = 4;
  localparam int T     = DEPTH + LANES - 1;
  localparam int VW    = LANES * DW;

  typedef logic [VW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic fire = 1'b0;
  logic pe_clr = 1'b0;
  vec_t in_data = '0;
  vec_t in_data_b = '0;
  logic in_ready, full, feed_valid, done;
  logic in_ready_b, full_b, feed_valid_b, done_b;
  vec_t lane_out, lane_out_b;

  int checks = 0;
  int errors = 0;
  int fv_seen = 0;
  int done_seen = 0;

  vec_t tile_a [DEPTH];
  vec_t tile_b [DEPTH];
  logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .fire(fire), .full(full), .lane_out(lane_out),
    .feed_valid(feed_valid), .done(done)
  );

  systolic_skew_feeder #(.DATA_WIDTH(DW), .LANES(LANES), .DEPTH(DEPTH)) u_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data_b), .fire(fire), .full(full_b), .lane_out(lane_out_b),
    .feed_valid(feed_valid_b), .done(done_b)
  );

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: tile is a list of accepted vectors; a replay is T steps
  // where step s puts element i of vector s-i on lane i.
  bit   m_on = 1'b0;
  bit   m_loaded = 1'b0;
  int   m_acc = 0;
  int   m_left = 0;
  vec_t m_tile [DEPTH];
  vec_t e_lane = '0;
  logic e_fv = 1'b0, e_done = 1'b0, e_ready = 1'b1, e_full = 1'b0;

  initial begin : model
    int s;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_on = 1'b1; m_loaded = 1'b0; m_acc = 0; m_left = 0;
        e_lane = '0; e_fv = 1'b0; e_done = 1'b0;
      end else if (m_on) begin
        e_lane = '0; e_fv = 1'b0; e_done = 1'b0;
        if (m_left > 0) begin
          s = T - m_left;
          for (int i = 0; i < LANES; i++)
            if (s - i >= 0 && s - i < DEPTH)
              e_lane[i*DW +: DW] = m_tile[s-i][i*DW +: DW];
          e_fv = 1'b1;
          e_done = (m_left == 1);
          m_left--;
        end else if (m_loaded) begin
          if (fire) begin
            m_left = T;
            m_loaded = 1'b0;
          end
        end else if (in_valid) begin
          m_tile[m_acc] = in_data;
          m_acc++;
          if (m_acc == DEPTH) begin
            m_loaded = 1'b1;
            m_acc = 0;
          end
        end
      end
      e_full  = m_loaded;
      e_ready = !m_loaded && (m_left == 0);
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("lane_out", lane_out, e_lane);
      chk("feed_valid", vec_t'(feed_valid), vec_t'(e_fv));
      chk("done", vec_t'(done), vec_t'(e_done));
      chk("in_ready", vec_t'(in_ready), vec_t'(e_ready));
      chk("full", vec_t'(full), vec_t'(e_full));
      if (feed_valid === 1'b1) fv_seen++;
      if (done === 1'b1) done_seen++;
    end
  end

  // Behavioural 4x4 output-stationary PE array: x moves right, w moves down.
  logic [DW-1:0] pe_x [LANES][LANES];
  logic [DW-1:0] pe_w [LANES][LANES];
  logic [DW-1:0] pe_acc [LANES][LANES];

  always @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        pe_x[i][j] <= (j == 0) ? lane_out[i*DW +: DW] : pe_x[i][j-1];
        pe_w[i][j] <= (i == 0) ? lane_out_b[j*DW +: DW] : pe_w[i-1][j];
        pe_acc[i][j] <= pe_clr ? '0 : pe_acc[i][j] +
          ((j == 0) ? lane_out[i*DW +: DW] : pe_x[i][j-1]) *
          ((i == 0) ? lane_out_b[j*DW +: DW] : pe_w[i-1][j]);
      end
    end
  end

  // mode 0: no stalls, 1: fixed 1,0,0,1,1,0,1 pattern, 2: random stalls
  task automatic send_tile(input int mode);
    int k = 0;
    int c = 0;
    logic v;
    while (k < DEPTH) begin
      case (mode)
        1:       v = pat[c % 7];
        2:       v = (c > 12) ? 1'b1 : 1'($urandom_range(0, 1));
        default: v = 1'b1;
      endcase
      in_valid  = v;
      in_data   = v ? tile_a[k] : {$urandom, $urandom, $urandom, $urandom};
      in_data_b = tile_b[k];
      tick();
      if (v) k++;
      c++;
    end
    in_valid = 1'b0;
  endtask

  task automatic rand_tile();
    for (int k = 0; k < DEPTH; k++) begin
      tile_a[k] = {$urandom, $urandom, $urandom, $urandom};
      tile_b[k] = '0;
    end
  endtask

  task automatic fire_run(input int delay);
    repeat (delay) tick();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    repeat (T + 1) tick();
  endtask

  initial begin : stim
    vec_t exp6;
    for (int k = 0; k < DEPTH; k++) tile_b[k] = '0;

    // Reset state
    rst = 1'b0;
    tick(); tick();
    chk("rst_in_ready", vec_t'(in_ready), vec_t'(1));
    chk("rst_full", vec_t'(full), vec_t'(0));
    chk("rst_lane_out", lane_out, '0);
    chk("rst_feed_valid", vec_t'(feed_valid), vec_t'(0));
    rst = 1'b1;
    tick();

    // Basic skew: element i of vector k = 10*k+i
    for (int k = 0; k < DEPTH; k++)
      for (int i = 0; i < LANES; i++)
        tile_a[k][i*DW +: DW] = DW'(10 * k + i);
    send_tile(0);
    chk("basic_full", vec_t'(full), vec_t'(1));
    fv_seen = 0;
    fire = 1'b1;
    tick();
    fire = 1'b0;
    exp6 = '0;
    exp6[3*DW +: DW] = 33;
    for (int s = 0; s < T; s++) begin
      tick();
      if (s == 0) chk("step0", lane_out, '0);
      if (s == 1) begin
        chk("step1_lane1", vec_t'(lane_out[1*DW +: DW]), vec_t'(1));
        chk("step1_lane0", vec_t'(lane_out[0*DW +: DW]), vec_t'(10));
      end
      if (s == 3) begin
        chk("step3_lane3", vec_t'(lane_out[3*DW +: DW]), vec_t'(3));
        chk("step3_lane0", vec_t'(lane_out[0*DW +: DW]), vec_t'(30));
      end
      if (s == 6) begin
        chk("step6_lanes", lane_out, exp6);
        chk("step6_done", vec_t'(done), vec_t'(1));
      end
    end
    tick();
    chk("basic_fv_cycles", vec_t'(fv_seen), vec_t'(7));

    // Stalled load, same tile
    send_tile(1);
    chk("stall_full", vec_t'(full), vec_t'(1));
    fv_seen = 0;
    fire_run(0);
    chk("stall_fv_cycles", vec_t'(fv_seen), vec_t'(7));

    // Fire held through load and run
    rand_tile();
    fire = 1'b1;
    send_tile(0);
    chk("fire_noearly", vec_t'(feed_valid), vec_t'(0));
    tick();
    chk("fire_step0_wait", vec_t'(feed_valid), vec_t'(0));
    tick();
    chk("fire_step0", vec_t'(feed_valid), vec_t'(1));
    repeat (T - 1) tick();
    chk("fire_done", vec_t'(done), vec_t'(1));
    repeat (3) tick();
    chk("fire_norestart", vec_t'(feed_valid), vec_t'(0));
    fire = 1'b0;
    tick();

    // Back-to-back tiles
    rand_tile();
    send_tile(0);
    fire = 1'b1;
    tick();
    fire = 1'b0;
    repeat (T) tick();
    chk("b2b_done", vec_t'(done), vec_t'(1));
    chk("b2b_ready", vec_t'(in_ready), vec_t'(1));
    rand_tile();
    send_tile(0);
    fire_run(0);

    // Reset mid-RUN at step 3
    rand_tile();
    send_tile(0);
    fire = 1'b1;
    tick();
    fire = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    done_seen = 0;
    tick();
    rst = 1'b1;
    chk("mid_rst_lane", lane_out, '0);
    chk("mid_rst_fv", vec_t'(feed_valid), vec_t'(0));
    chk("mid_rst_ready", vec_t'(in_ready), vec_t'(1));
    repeat (T) tick();
    chk("mid_rst_nodone", vec_t'(done_seen), vec_t'(0));
    rand_tile();
    send_tile(0);
    fire_run(1);

    // Random tiles, stalls and fire delays
    for (int n = 0; n < 5; n++) begin
      rand_tile();
      send_tile(2);
      fire_run(int'($urandom_range(0, 3)));
    end

    // End-to-end: A = I on x, B = [1..16] on w
    for (int k = 0; k < DEPTH; k++)
      for (int i = 0; i < LANES; i++) begin
        tile_a[k][i*DW +: DW] = (i == k) ? DW'(1) : DW'(0);
        tile_b[k][i*DW +: DW] = DW'(4 * k + i + 1);
      end
    pe_clr = 1'b1;
    tick();
    pe_clr = 1'b0;
    send_tile(0);
    chk("e2e_full_b", vec_t'(full_b), vec_t'(1));
    fire = 1'b1;
    tick();
    fire = 1'b0;
    repeat (T + LANES + 2) tick();
    for (int i = 0; i < LANES; i++)
      for (int j = 0; j < LANES; j++)
        chk($sformatf("e2e_y_%0d_%0d", i, j), vec_t'(pe_acc[i][j]), vec_t'(4 * i + j + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
